// File: rtl/data_mem_sram_port.sv
// Single-port word array serving round-robin arbitrated read/write channels with a fixed
// access latency, plus a host load port and a combinational debug read port.
module data_mem_sram_port #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LATENCY      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              load_valid,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data,
  output logic                              load_ready,
  input  logic [ADDR_BITS-1:0]              dbg_address,
  output logic [DATA_BITS-1:0]              dbg_data,
  output logic                              busy
);

  localparam int unsigned ChBits = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned Depth  = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  state_e                            r_state;
  state_e                            w_state_d;
  logic [DATA_BITS-1:0]              r_mem [Depth];
  logic [ChBits-1:0]                 r_rr_ptr;
  logic [ChBits-1:0]                 r_ch;
  logic                              r_is_write;
  logic [ADDR_BITS-1:0]              r_addr;
  logic [DATA_BITS-1:0]              r_wdata;
  logic [3:0]                        r_cnt;
  logic [NUM_CHANNELS-1:0]           r_rblock;
  logic [NUM_CHANNELS-1:0]           r_wblock;
  logic [NUM_CHANNELS-1:0]           r_read_ready;
  logic [NUM_CHANNELS-1:0]           r_write_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] r_read_data;

  logic [NUM_CHANNELS-1:0] w_rreq;
  logic [NUM_CHANNELS-1:0] w_wreq;
  logic [NUM_CHANNELS-1:0] w_elig;
  logic [ChBits-1:0]       w_gnt_ch;
  logic [ChBits-1:0]       w_cand;
  logic [ChBits-1:0]       w_next_ptr;
  logic                    w_found;
  logic                    w_gnt_write;
  logic [ADDR_BITS-1:0]    w_gnt_addr;
  logic [DATA_BITS-1:0]    w_gnt_wdata;
  logic                    w_idle;
  logic                    w_grant;
  logic                    w_access;
  int unsigned             w_idx;

  assign w_rreq = mem_read_valid & ~r_rblock;
  assign w_wreq = mem_write_valid & ~r_wblock;
  assign w_elig = w_rreq | w_wreq;

  // First eligible channel at or above the round-robin pointer, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_ch = '0;
    w_idx    = 0;
    w_cand   = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      w_idx = i + 32'(r_rr_ptr);
      if (w_idx >= NUM_CHANNELS) w_idx = w_idx - NUM_CHANNELS;
      w_cand = ChBits'(w_idx);
      if (!w_found && w_elig[w_cand]) begin
        w_found  = 1'b1;
        w_gnt_ch = w_cand;
      end
    end
  end

  // A pending write on the granted channel goes ahead of its read.
  always_comb begin
    w_gnt_write = w_wreq[w_gnt_ch];
    w_gnt_addr  = w_gnt_write ? mem_write_address[w_gnt_ch*ADDR_BITS +: ADDR_BITS]
                              : mem_read_address[w_gnt_ch*ADDR_BITS +: ADDR_BITS];
    w_gnt_wdata = mem_write_data[w_gnt_ch*DATA_BITS +: DATA_BITS];
    w_next_ptr  = (w_gnt_ch == ChBits'(NUM_CHANNELS - 1)) ? '0 : w_gnt_ch + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (!load_valid && w_found) w_state_d = StWait;
      StWait:    if (r_cnt == '0) w_state_d = StRespond;
      StRespond: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_idle     = (r_state == StIdle);
    w_grant    = w_idle && !load_valid && w_found;
    w_access   = (r_state == StWait) && (r_cnt == '0);
    load_ready = w_idle;
    busy       = !w_idle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_ch          <= '0;
      r_is_write    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rblock      <= '0;
      r_wblock      <= '0;
      r_read_ready  <= '0;
      r_write_ready <= '0;
      r_read_data   <= '0;
    end else begin
      r_read_ready  <= '0;
      r_write_ready <= '0;
      // A block bit survives only while its valid stays high; completion re-arms it below.
      r_rblock      <= r_rblock & mem_read_valid;
      r_wblock      <= r_wblock & mem_write_valid;
      if (w_grant) begin
        r_ch       <= w_gnt_ch;
        r_is_write <= w_gnt_write;
        r_addr     <= w_gnt_addr;
        r_wdata    <= w_gnt_wdata;
        r_cnt      <= 4'(LATENCY);
        r_rr_ptr   <= w_next_ptr;
      end
      if ((r_state == StWait) && (r_cnt != '0)) r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        if (r_is_write) begin
          r_write_ready[r_ch] <= 1'b1;
          r_wblock[r_ch]      <= 1'b1;
        end else begin
          r_read_ready[r_ch]                         <= 1'b1;
          r_rblock[r_ch]                             <= 1'b1;
          r_read_data[r_ch*DATA_BITS +: DATA_BITS]   <= r_mem[r_addr];
        end
      end
    end
  end

  // Array contents survive reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_idle && load_valid)        r_mem[load_address] <= load_data;
      else if (w_access && r_is_write) r_mem[r_addr]       <= r_wdata;
    end
  end

  assign mem_read_ready  = r_read_ready;
  assign mem_write_ready = r_write_ready;
  assign mem_read_data   = r_read_data;
  assign dbg_data        = r_mem[dbg_address];

endmodule

// File: tb/tb_data_mem_sram_port.sv
// Scoreboard bench for data_mem_sram_port: per-channel expected queues filled at issue,
// drained by a monitor on each ready pulse; a flat array models memory contents.
module tb_data_mem_sram_port;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int LAT = 2;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0]    mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [NC*AB-1:0] mem_read_address, mem_write_address;
  logic [NC*DB-1:0] mem_read_data, mem_write_data;
  logic             load_valid = 1'b0;
  logic [AB-1:0]    load_address = '0;
  logic [DB-1:0]    load_data = '0;
  logic             load_ready, busy;
  logic [AB-1:0]    dbg_address = '0;
  logic [DB-1:0]    dbg_data;

  logic          tb_rv [NC];
  logic          tb_wv [NC];
  logic [AB-1:0] tb_ra [NC];
  logic [AB-1:0] tb_wa [NC];
  logic [DB-1:0] tb_wd [NC];

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      mem_read_valid[c]              = tb_rv[c];
      mem_write_valid[c]             = tb_wv[c];
      mem_read_address[c*AB +: AB]   = tb_ra[c];
      mem_write_address[c*AB +: AB]  = tb_wa[c];
      mem_write_data[c*DB +: DB]     = tb_wd[c];
    end
  end

  data_mem_sram_port #(
    .ADDR_BITS   (AB),
    .DATA_BITS   (DB),
    .NUM_CHANNELS(NC),
    .LATENCY     (LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .mem_write_valid  (mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready),
    .load_valid       (load_valid),
    .load_address     (load_address),
    .load_data        (load_data),
    .load_ready       (load_ready),
    .dbg_address      (dbg_address),
    .dbg_data         (dbg_data),
    .busy             (busy)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DB-1:0] model_mem [256];
  logic [DB-1:0] exp_rd [NC][$];
  int            exp_wr [NC];
  int            done_q [$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the head of that channel's expectation queue.
  always @(negedge clk) begin : p_mon
    int            nrdy;
    logic [DB-1:0] e;
    nrdy = $countones({mem_read_ready, mem_write_ready});
    if (nrdy != 0) begin
      checks++;
      if (nrdy != 1) begin
        errors++;
        $display("FAIL single_port_ready actual=%0d required=1", nrdy);
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (mem_read_ready[c]) begin
        done_q.push_back(c);
        checks++;
        if (exp_rd[c].size() == 0) begin
          errors++;
          $display("FAIL unexpected_read_ready ch%0d actual=1 required=0", c);
        end else begin
          e = exp_rd[c].pop_front();
          if (mem_read_data[c*DB +: DB] !== e) begin
            errors++;
            $display("FAIL read_data ch%0d actual=0x%0h required=0x%0h", c,
                     mem_read_data[c*DB +: DB], e);
          end
        end
      end
      if (mem_write_ready[c]) begin
        done_q.push_back(c + 100);
        checks++;
        if (exp_wr[c] == 0) begin
          errors++;
          $display("FAIL unexpected_write_ready ch%0d actual=1 required=0", c);
        end else begin
          exp_wr[c]--;
        end
      end
    end
  end

  task automatic wait_ready(input int c, input bit wr, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr ? mem_write_ready[c] : mem_read_ready[c]) && n < TMO);
    if (!(wr ? mem_write_ready[c] : mem_read_ready[c])) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout ch%0d wr=%0d actual=0 required=1", c, wr);
    end
  endtask

  task automatic do_read(input int c, input logic [AB-1:0] a, output int lat);
    exp_rd[c].push_back(model_mem[a]);
    tb_ra[c] = a;
    tb_rv[c] = 1'b1;
    wait_ready(c, 1'b0, lat);
    tb_rv[c] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input int c, input logic [AB-1:0] a, input logic [DB-1:0] d);
    int n;
    exp_wr[c]++;
    model_mem[a] = d;
    tb_wa[c] = a;
    tb_wd[c] = d;
    tb_wv[c] = 1'b1;
    wait_ready(c, 1'b1, n);
    tb_wv[c] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [AB-1:0] a, input logic [DB-1:0] d);
    load_valid   = 1'b1;
    load_address = a;
    load_data    = d;
    model_mem[a] = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic check_rr(input int start, input string tag);
    int rl;
    done_q.delete();
    fork
      do_read(0, 8'h80, rl);
      do_read(1, 8'h81, rl);
      do_read(2, 8'h82, rl);
      do_read(3, 8'h83, rl);
    join
    chk({tag, "_count"}, done_q.size(), NC);
    for (int k = 0; k < NC && k < done_q.size(); k++)
      chk($sformatf("%s_order%0d", tag, k), done_q[k], (start + k) % NC);
  endtask

  task automatic rand_chan(input int c);
    for (int k = 0; k < 12; k++) begin
      logic [AB-1:0] a;
      int            lat;
      a = {c[1:0], 6'($urandom_range(0, 63))};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) do_write(c, a, 8'($urandom));
      else                           do_read(c, a, lat);
    end
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int lat;
    int pulses;
    for (int c = 0; c < NC; c++) begin
      tb_rv[c] = 1'b0;
      tb_wv[c] = 1'b0;
      tb_ra[c] = '0;
      tb_wa[c] = '0;
      tb_wd[c] = '0;
      exp_wr[c] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_read_ready", mem_read_ready, 0);
    chk("rst_write_ready", mem_write_ready, 0);
    chk("rst_read_data", mem_read_data, 0);
    reset = 1'b0;

    // Preload the whole array so every later read has a known expectation.
    load_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      load_address = 8'(a);
      load_data    = 8'($urandom);
      model_mem[a] = load_data;
      @(negedge clk);
    end
    load_valid = 1'b0;

    // Preload and read with latency/hold checks.
    do_load(8'h10, 8'hAB);
    dbg_address = 8'h10;
    #1 chk("dbg_after_load", dbg_data, 8'hAB);
    do_read(0, 8'h10, lat);
    chk("read_latency_edges", lat, LAT + 2);
    repeat (3) @(negedge clk);
    chk("read_data_held", mem_read_data[0 +: DB], 8'hAB);

    // Write then debug read.
    do_write(2, 8'h33, 8'h5C);
    dbg_address = 8'h33;
    #1 chk("dbg_after_write", dbg_data, 8'h5C);

    // Round-robin: steer the pointer to 0, then to 2.
    do_read(3, 8'h90, lat);
    check_rr(0, "rr_from0");
    do_read(1, 8'h91, lat);
    check_rr(2, "rr_from2");

    // Same-channel write and read: write first, read returns the new value.
    done_q.delete();
    exp_wr[1]++;
    model_mem[8'h40] = 8'h77;
    exp_rd[1].push_back(model_mem[8'h40]);
    tb_wa[1] = 8'h40;
    tb_wd[1] = 8'h77;
    tb_ra[1] = 8'h40;
    tb_wv[1] = 1'b1;
    tb_rv[1] = 1'b1;
    wait_ready(1, 1'b1, lat);
    tb_wv[1] = 1'b0;
    wait_ready(1, 1'b0, lat);
    tb_rv[1] = 1'b0;
    @(negedge clk);
    chk("wr_rd_count", done_q.size(), 2);
    if (done_q.size() >= 2) begin
      chk("wr_rd_first_write", done_q[0], 101);
      chk("wr_rd_then_read", done_q[1], 1);
    end

    // Block bit: valid held after ready yields a single pulse until it drops.
    exp_rd[3].push_back(model_mem[8'hC5]);
    tb_ra[3] = 8'hC5;
    tb_rv[3] = 1'b1;
    wait_ready(3, 1'b0, lat);
    pulses = mem_read_ready[3] ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_read_ready[3]) pulses++;
    end
    chk("block_single_pulse", pulses, 1);
    tb_rv[3] = 1'b0;
    @(negedge clk);
    exp_rd[3].push_back(model_mem[8'hC5]);
    tb_rv[3] = 1'b1;
    wait_ready(3, 1'b0, lat);
    chk("block_second_access", mem_read_ready[3], 1);
    tb_rv[3] = 1'b0;
    @(negedge clk);

    // Reset during WAIT of a write drops the access.
    do_load(8'h20, 8'h11);
    tb_wa[0] = 8'h20;
    tb_wd[0] = 8'hEE;
    tb_wv[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_granted_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_load_ready", load_ready, 1);
    chk("mid_rst_read_data", mem_read_data, 0);
    tb_wv[0] = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_write_ready[0]) pulses++;
      reset = 1'b0;
    end
    chk("mid_rst_no_ready", pulses, 0);
    dbg_address = 8'h20;
    #1 chk("mid_rst_array_kept", dbg_data, model_mem[8'h20]);

    // Randomised traffic on disjoint per-channel address ranges.
    fork
      rand_chan(0);
      rand_chan(1);
      rand_chan(2);
      rand_chan(3);
    join
    repeat (4) @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("drain_rd_ch%0d", c), exp_rd[c].size(), 0);
      chk($sformatf("drain_wr_ch%0d", c), exp_wr[c], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_sram_port.md
# data_mem_sram_port

Single-port memory back-end that terminates the GPU's multi-channel data-memory interface. It sits directly downstream of `gpu`'s `data_mem_*` ports and serves read and write requests from all channels out of one internal word array. Channels are picked round-robin, and each access has a fixed, parameterised access latency. A host load/debug port lets the testbench or a loader preload the array and inspect it around a kernel launch.

## Interface
- `ADDR_BITS`, default 8: address width; the array holds 2^ADDR_BITS words.
- `DATA_BITS`, default 8: word width.
- `NUM_CHANNELS`, default 4: number of request channels; matches the GPU's data-memory channel count.
- `LATENCY`, default 2: extra wait cycles per access; legal range is 0–15.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_read_valid`  in  [NUM_CHANNELS]  per-channel read request.
- `mem_read_address`  in  [ADDR_BITS] x NUM_CHANNELS  read address for each channel.
- `mem_read_ready`  out  [NUM_CHANNELS]  one-cycle read-completion pulse; data is valid in the same cycle.
- `mem_read_data`  out  [DATA_BITS] x NUM_CHANNELS  registered read data; held until that channel's next read completes.
- `mem_write_valid`  in  [NUM_CHANNELS]  per-channel write request.
- `mem_write_address`  in  [ADDR_BITS] x NUM_CHANNELS  write address for each channel.
- `mem_write_data`  in  [DATA_BITS] x NUM_CHANNELS  write data for each channel.
- `mem_write_ready`  out  [NUM_CHANNELS]  one-cycle write-completion pulse.
- `load_valid`  in  1  host write request.
- `load_address`  in  ADDR_BITS  host write address.
- `load_data`  in  DATA_BITS  host write data.
- `load_ready`  out  1  combinational; high exactly when the FSM is in IDLE.
- `dbg_address`  in  ADDR_BITS  host inspection address.
- `dbg_data`  out  DATA_BITS  combinational read of `array[dbg_address]`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:**
  - IDLE: arbitrate among eligible channels, or accept a host load.
  - WAIT: count down the access latency for the granted request.
  - RESPOND: pulse the completion signal for the granted request, then return to IDLE.
- **Request vectors:**
  - `rreq[c] = mem_read_valid[c] & ~rblock[c]`
  - `wreq[c] = mem_write_valid[c] & ~wblock[c]`
  - A channel is eligible if `rreq[c] | wreq[c]`.
- **Priority in IDLE:**
  - A host load wins over all channels. `load_valid` writes the array at that edge and the FSM stays in IDLE.
  - Otherwise, grant the first eligible channel at or after `rr_ptr`, searching upward with wrap-around.
- **Grant latching:**
  - The grant latches the channel index, the direction, the address and the write data.
  - Write beats read on the same channel: if both `wreq[c]` and `rreq[c]` are set, the write is granted first.
  - The pending read stays eligible and is served on a later grant.
  - After a grant, `rr_ptr` becomes the granted index + 1, modulo NUM_CHANNELS.
- **WAIT:** loaded with `LATENCY` and decremented each edge. When the counter is 0, the FSM moves to RESPOND. With `LATENCY=0`, WAIT lasts one cycle.
- **Entry into RESPOND:**
  - On the edge entering RESPOND, the access is performed.
  - For a read, `mem_read_data[c]` is loaded from the array.
  - For a write, the array word is written.
  - The matching ready bit is registered high, and the matching block bit is set.
- **RESPOND:** lasts one cycle. The ready bit is cleared on the exit edge.
- **Block bits:**
  - `rblock[c]` or `wblock[c]` is set at completion.
  - It is cleared on any edge where the corresponding valid is sampled low.
  - This stops a still-high valid in the cycle after ready from being served twice.
- **Width rules:** addresses index the array directly; there is no wrap or bounds logic beyond ADDR_BITS. Data is stored unmodified.
- **Reset:**
  - Asynchronous; the FSM goes to IDLE.
  - Cleared to 0: `rr_ptr`, all ready bits, all block bits, and `mem_read_data`.
  - `busy=0`, `load_ready=1`.
  - The array is not cleared.
  - Reset mid-access drops the access: no array write and no ready pulse.

## Timing
- Let E0 be the IDLE edge where a request is granted.
- Ready is high during the cycle after edge E0+LATENCY+1. With LATENCY=2, ready is high for exactly one cycle, starting 3 edges after the grant.
- Minimum spacing between two grants is LATENCY+3 edges, counting the IDLE edge.
- A host load during IDLE costs one edge and delays channel arbitration by one cycle.
- `dbg_data` reflects an array write in the cycle after the write edge.

## Test plan
- **Preload and read:** after reset, load `0x10→0xAB`. Channel 0 reads `0x10` with LATENCY=2.
  - `mem_read_ready[0]` pulses for 1 cycle, 3 edges after the grant.
  - `mem_read_data[0]=0xAB` and stays held afterwards.
- **Write then debug read:** channel 2 writes `0x5C` to `0x33`.
  - `mem_write_ready[2]` pulses once.
  - `dbg_address=0x33` shows `0x5C`.
- **Round-robin fairness:** all 4 channels read distinct addresses at once and keep valid high until their ready.
  - Grants come in order 0,1,2,3, each exactly once.
  - With `rr_ptr` initially 2, the order is 2,3,0,1.
- **Same-channel write and read:** channel 1 asserts both a write (`0x40←0x77`) and a read (`0x40`).
  - The write completes first.
  - The read then returns `0x77`.
- **Block bit:** channel 3 holds `mem_read_valid` high for 4 cycles after its ready.
  - Exactly one ready pulse occurs.
  - Dropping valid for one cycle and re-raising it produces a second access.
- **Reset mid-access:** assert `reset` during WAIT of a write of `0xEE` to `0x20` (previously `0x11`).
  - No ready pulse.
  - `array[0x20]` is still `0x11`.
  - Outputs return to their reset values asynchronously.
